// File: rtl/gf2_kara_seq.sv
// Sequential GF(2) polynomial multiplier: one-level Karatsuba over a shared
// (N/2)x(N/2) carry-less multiplier, with optional one-cycle reduction.
module gf2_kara_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           mode,
  input  logic [N-1:0]   poly,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y
);

  localparam int H = N / 2;
  localparam int W = 2 * N - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P2   = 3'd2,
    S_PM   = 3'd3,
    S_COMB = 3'd4,
    S_RED  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  function automatic logic [N-2:0] clmul_half(input logic [H-1:0] x, input logic [H-1:0] z);
    logic [N-2:0] acc;
    acc = '0;
    for (int i = 0; i < H; i++) begin
      if (z[i]) begin
        acc = acc ^ ({{(N-1-H){1'b0}}, x} << i);
      end
    end
    return acc;
  endfunction

  // Folds every coefficient above x^(N-1) back down using x^N == poly.
  function automatic logic [W-1:0] reduce_mod(input logic [W-1:0] r, input logic [N-1:0] p);
    logic [W-1:0] t;
    t = r;
    for (int k = W - 1; k >= N; k--) begin
      if (t[k]) begin
        t[k-1 -: N] = t[k-1 -: N] ^ p;
        t[k]        = 1'b0;
      end
    end
    return t;
  endfunction

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, poly_q, poly_d;
  logic         mode_q, mode_d;
  logic [N-2:0] p0_q, p0_d, p2_q, p2_d, pm_q, pm_d;
  logic [W-1:0] r_q, r_d, y_q, y_d;
  logic         out_valid_q, out_valid_d;

  logic [H-1:0] mul_x_s, mul_z_s;
  logic [N-2:0] mul_s, z1_s;
  logic [W-1:0] comb_s;

  // Operand steering for the shared half-width multiplier.
  always_comb begin
    mul_x_s = '0;
    mul_z_s = '0;
    case (state_q)
      S_P0: begin
        mul_x_s = a_q[H-1:0];
        mul_z_s = b_q[H-1:0];
      end
      S_P2: begin
        mul_x_s = a_q[N-1:H];
        mul_z_s = b_q[N-1:H];
      end
      S_PM: begin
        mul_x_s = a_q[H-1:0] ^ a_q[N-1:H];
        mul_z_s = b_q[H-1:0] ^ b_q[N-1:H];
      end
      default: begin
        mul_x_s = '0;
        mul_z_s = '0;
      end
    endcase
  end

  assign mul_s  = clmul_half(mul_x_s, mul_z_s);
  assign z1_s   = pm_q ^ p0_q ^ p2_q;
  assign comb_s = {{N{1'b0}}, p0_q} ^ ({{N{1'b0}}, z1_s} << H) ^ {p2_q, {N{1'b0}}};

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    poly_d      = poly_q;
    p0_d        = p0_q;
    p2_d        = p2_q;
    pm_d        = pm_q;
    r_d         = r_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          poly_d  = poly;
          state_d = S_P0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P0: begin
        p0_d    = mul_s;
        state_d = S_P2;
      end
      S_P2: begin
        p2_d    = mul_s;
        state_d = S_PM;
      end
      S_PM: begin
        pm_d    = mul_s;
        state_d = S_COMB;
      end
      S_COMB: begin
        r_d = comb_s;
        if (mode_q) begin
          state_d = S_RED;
        end else begin
          y_d         = comb_s;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_RED: begin
        y_d         = reduce_mod(r_q, poly_q);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, discarding any result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      poly_q      <= '0;
      p0_q        <= '0;
      p2_q        <= '0;
      pm_q        <= '0;
      r_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      poly_q      <= poly_d;
      p0_q        <= p0_d;
      p2_q        <= p2_d;
      pm_q        <= pm_d;
      r_q         <= r_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: doc/gf2_kara_seq.md
GF2_KARA_SEQ -- requirements
Module: gf2_kara_seq

Interface
REQ-001 SHALL have parameter N, default 16, operand width in bits; even and >= 4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a, input, N, multiplicand polynomial over GF(2); bit i is coefficient of x^i.
REQ-007 SHALL have port b, input, N, multiplier polynomial over GF(2).
REQ-008 SHALL have port mode, input, 1, 0 = full product, 1 = product reduced modulo x^N + poly.
REQ-009 SHALL have port poly, input, N, low coefficients of the reduction polynomial; used only when mode=1.
REQ-010 SHALL have port out_valid, output, 1, y holds a completed result.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts y.
REQ-012 SHALL have port y, output, 2N-1, carry-less product, or reduced product in y[N-1:0] with y[2N-2:N]=0.

Function
REQ-013 SHALL capture a, b, mode and poly into internal registers on the cycle in_valid && in_ready; later input changes have no effect on that operation.
REQ-014 SHALL assert in_ready only in state IDLE; in_valid in any other state is ignored and nothing is captured.
REQ-015 SHALL use one shared combinational (N/2)x(N/2) carry-less multiplier with an (N-1)-bit result, time-multiplexed over three cycles.
REQ-016 SHALL sequence through IDLE -> P0 -> P2 -> PM -> COMB -> (RED if mode=1) -> DONE -> IDLE.
REQ-017 P0 SHALL register P0 = al*bl. P2 SHALL register P2 = ah*bh. PM SHALL register PM = (al^ah)*(bl^bh). al/ah are the low/high N/2 bits of a; bl/bh likewise of b.
REQ-018 COMB SHALL form Z1 = PM^P0^P2 and R = P0 ^ (Z1<<N/2) ^ (P2<<N), truncated to 2N-1 bits. All additions are XOR; there are no carries.
REQ-019 RED SHALL fold R in one cycle: for k = 2N-2 down to N, if bit k is set, XOR (poly<<(k-N)) into bits k-1..k-N and clear bit k. The result is zero-extended to 2N-1 bits.
REQ-020 SHALL register y and assert out_valid on entry to DONE. Latency from the accept edge to out_valid: 5 cycles for mode=0 and 6 cycles for mode=1.
REQ-021 In DONE, y and out_valid SHALL hold stable until out_ready=1. On that edge the block returns to IDLE and deasserts out_valid.
REQ-022 y SHALL keep its last value after consumption. It is meaningful only while out_valid=1.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 in_ready SHALL be 1 in the cycle following consumption. A new operation is never accepted in the same cycle as consumption.

Reset
REQ-025 While rst=1, the block SHALL be in state IDLE, with in_ready=1, out_valid=0, y=0, and all operand and partial-product registers at 0.
REQ-026 rst asserted mid-operation, including during DONE with a pending result, SHALL abort the operation and discard the result. Any in_valid on the first edge after release is accepted normally.

Verification
REQ-027 N=16, mode=0, a=0xFFFF, b=0xFFFF: y=0x55555555, with out_valid 5 cycles after accept.
REQ-028 N=16, mode=0, a=0x0002, b=0x8000: y=0x00010000. Then mode=1, poly=0x002B, same operands: y=0x0000002B, with out_valid 6 cycles after accept.
REQ-029 a=0x0000, b=0xBEEF in either mode: y=0. Also 1000 random (a, b, mode, poly) vectors checked against a bitwise shift-XOR reference model.
REQ-030 Hold out_ready=0 for 4 cycles in DONE, with in_valid=1 and changing a and b: y and out_valid are unchanged and in_ready=0. Release out_ready: the result is consumed, and the held in_valid is accepted on the next cycle.
REQ-031 Assert rst during PM: out_valid=0 and in_ready=1 immediately (asynchronously). A new operation after release (a=0x0003, b=0x0003, mode=0) gives y=0x00000005.
